// File: rtl/gin_wr_arbiter.sv
// Round-robin arbiter sharing the GIN tags/data FIFO write port among NUM_REQ producers; optional stats via GIN_ARB_STATS_EN.
// Latency: one IDLE arbitration cycle per burst, then one beat per cycle combinationally passed to the FIFOs.
// Backpressure: tags_full or data_full stalls the grantee (req_ready=0, no write); grant is held until last beat or BURST_MAX.
module gin_wr_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int BURST_MAX     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             arb_enable,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*ROW_TAG_WIDTH-1:0] req_row_tag,
    input  logic [NUM_REQ*COL_TAG_WIDTH-1:0] req_col_tag,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [DATA_WIDTH-1:0]            data_in,
    output logic [ROW_TAG_WIDTH-1:0]         row_tag,
    output logic [COL_TAG_WIDTH-1:0]         col_tag,
    output logic                             data_wr_en,
    output logic                             tags_wr_en,
    input  logic                             tags_full,
    input  logic                             data_full,
    output logic                             grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]       grant_idx,
`ifdef GIN_ARB_STATS_EN
    output logic [31:0]                      beat_count,
    output logic [31:0]                      stall_count,
`endif
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   next_ptr;
    logic               grant_vld;
    logic               xfer;
    logic               burst_end;

    // Rotating-priority search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr_q) + k >= NUM_REQ) begin
                cand = IDX_W'(int'(rr_ptr_q) + k - NUM_REQ);
            end else begin
                cand = IDX_W'(int'(rr_ptr_q) + k);
            end
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Beat transfer path: a write needs the grantee's valid and room in both FIFOs, keeping them aligned
    always_comb begin
        grant_vld = (state_q == GRANT);
        xfer      = grant_vld & req_valid[grant_idx_q] & ~tags_full & ~data_full;
        burst_end = xfer & (req_last[grant_idx_q] | (beat_cnt_q == CNT_W'(BURST_MAX - 1)));
        next_ptr  = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);

        req_ready              = '0;
        req_ready[grant_idx_q] = xfer;
        data_wr_en             = xfer;
        tags_wr_en             = xfer;

        data_in = '0;
        row_tag = '0;
        col_tag = '0;
        if (grant_vld) begin
            data_in = req_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
            row_tag = req_row_tag[grant_idx_q*ROW_TAG_WIDTH +: ROW_TAG_WIDTH];
            col_tag = req_col_tag[grant_idx_q*COL_TAG_WIDTH +: COL_TAG_WIDTH];
        end
    end

    // FSM next state: IDLE arbitrates, GRANT runs until the burst ends (arb_enable never cuts a burst)
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_enable && pick_vld) state_d = GRANT;
            GRANT:   if (burst_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant index, round-robin pointer and per-burst beat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && state_d == GRANT) begin
                grant_idx_q <= pick_idx;
            end
            if (burst_end) begin
                beat_cnt_q <= '0;
                rr_ptr_q   <= next_ptr;
            end else if (xfer) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef GIN_ARB_STATS_EN
    // Saturating counters of transferred beats and stalled grant cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (xfer && beat_count != 32'hFFFF_FFFF) begin
                beat_count <= beat_count + 32'd1;
            end
            if (grant_vld && !xfer && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

    assign grant_valid = grant_vld;
    assign grant_idx   = grant_idx_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gin_wr_arbiter.sv
// Randomized and directed bench for gin_wr_arbiter against a burst-level reference model.
// Latency: checks every cycle on the falling edge; inputs change 1ns after the rising edge.
// Backpressure: producers hold each beat until req_ready; fulls forced or randomized per scenario.
module tb_gin_wr_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int BM = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arb_enable;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N*RW-1:0] req_row_tag;
    logic [N*CW-1:0] req_col_tag;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   data_in;
    logic [RW-1:0]   row_tag;
    logic [CW-1:0]   col_tag;
    logic            data_wr_en;
    logic            tags_wr_en;
    logic            tags_full;
    logic            data_full;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic            busy;
`ifdef GIN_ARB_STATS_EN
    logic [31:0]     beat_count;
    logic [31:0]     stall_count;
`endif

    gin_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .reset(reset), .arb_enable(arb_enable),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_row_tag(req_row_tag), .req_col_tag(req_col_tag), .req_ready(req_ready),
        .data_in(data_in), .row_tag(row_tag), .col_tag(col_tag),
        .data_wr_en(data_wr_en), .tags_wr_en(tags_wr_en),
        .tags_full(tags_full), .data_full(data_full),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
`ifdef GIN_ARB_STATS_EN
        .beat_count(beat_count), .stall_count(stall_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t pq [N][$];
    int    seq [N];
    int    glog_idx [$];
    int    glog_beats [$];
    int    wr_total = 0;
    logic  prev_gv = 1'b0;
    logic  gaps = 1'b0;
    logic  rnd_full = 1'b0;
    logic  force_df = 1'b0;
    logic  force_tf = 1'b0;

    // Reference model: current owner (-1 when none), next preferred requester, beats moved in this burst
    int m_g = -1;
    int m_ptr = 0;
    int m_beats = 0;
    int m_gidx = 0;
    longint unsigned m_bc = 0;
    longint unsigned m_sc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int gidx_at(input int k);
        return (k < glog_idx.size()) ? glog_idx[k] : 99;
    endfunction

    function automatic int gbeats_at(input int k);
        return (k < glog_beats.size()) ? glog_beats[k] : -1;
    endfunction

    task automatic push_burst(input int i, input int n, input bit with_last);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.d = {8'(i), 24'(seq[i]), 32'($urandom())};
            bt.r = 4'($urandom());
            bt.c = 4'($urandom());
            bt.l = with_last && (b == n - 1);
            pq[i].push_back(bt);
            seq[i]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                req_valid[i]            = 1'b1;
                req_last[i]             = pq[i][0].l;
                req_data[i*DW +: DW]    = pq[i][0].d;
                req_row_tag[i*RW +: RW] = pq[i][0].r;
                req_col_tag[i*CW +: CW] = pq[i][0].c;
            end else begin
                req_valid[i]            = 1'b0;
                req_last[i]             = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW]    = {$urandom(), $urandom()};
                req_row_tag[i*RW +: RW] = 4'($urandom());
                req_col_tag[i*CW +: CW] = 4'($urandom());
            end
        end
        tags_full = force_tf | (rnd_full && $urandom_range(0, 4) == 0);
        data_full = force_df | (rnd_full && $urandom_range(0, 4) == 0);
    endtask

    task automatic tick();
        logic          exp_gv;
        logic          exp_x;
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_d;
        logic [RW-1:0] exp_r;
        logic [CW-1:0] exp_c;
        @(negedge clk);
        exp_gv  = (m_g >= 0);
        exp_x   = exp_gv && req_valid[m_g] && !tags_full && !data_full;
        exp_rdy = '0;
        exp_d   = '0;
        exp_r   = '0;
        exp_c   = '0;
        if (exp_x) exp_rdy[m_g] = 1'b1;
        if (exp_gv) begin
            exp_d = req_data[m_g*DW +: DW];
            exp_r = req_row_tag[m_g*RW +: RW];
            exp_c = req_col_tag[m_g*CW +: CW];
        end
        chk("grant_valid", 64'(grant_valid), 64'(exp_gv));
        chk("busy", 64'(busy), 64'(exp_gv));
        chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("data_wr_en", 64'(data_wr_en), 64'(exp_x));
        chk("tags_wr_en", 64'(tags_wr_en), 64'(exp_x));
        chk("data_in", data_in, exp_d);
        chk("row_tag", 64'(row_tag), 64'(exp_r));
        chk("col_tag", 64'(col_tag), 64'(exp_c));
`ifdef GIN_ARB_STATS_EN
        chk("beat_count", 64'(beat_count), m_bc);
        chk("stall_count", 64'(stall_count), m_sc);
        if (exp_x && m_bc < 64'hFFFF_FFFF) m_bc++;
        if (exp_gv && !exp_x && m_sc < 64'hFFFF_FFFF) m_sc++;
`endif
        // Observation log of grants and the beats each one moved
        if (grant_valid && !prev_gv) begin
            glog_idx.push_back(int'(grant_idx));
            glog_beats.push_back(0);
        end
        prev_gv = grant_valid;
        if (data_wr_en) begin
            wr_total++;
            if (glog_beats.size() > 0) glog_beats[glog_beats.size()-1]++;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        // Model advance
        if (exp_gv) begin
            if (exp_x) begin
                m_beats++;
                if (req_last[m_g] || m_beats == BM) begin
                    m_ptr   = (m_gidx + 1) % N;
                    m_g     = -1;
                    m_beats = 0;
                end
            end
        end else if (arb_enable && req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_g    = c;
                    m_gidx = c;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_data_wr_en", 64'(data_wr_en), 64'd0);
        chk("rst_tags_wr_en", 64'(tags_wr_en), 64'd0);
        chk("rst_data_in", data_in, 64'd0);
        chk("rst_row_tag", 64'(row_tag), 64'd0);
        chk("rst_col_tag", 64'(col_tag), 64'd0);
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef GIN_ARB_STATS_EN
        chk("rst_beat_count", 64'(beat_count), 64'd0);
        chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        for (int i = 0; i < N; i++) pq[i].delete();
        m_g = -1; m_ptr = 0; m_beats = 0; m_gidx = 0; m_bc = 0; m_sc = 0;
        prev_gv = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; req_row_tag = '0; req_col_tag = '0;
        tags_full = 1'b0; data_full = 1'b0; force_df = 1'b0; force_tf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int g0;
        int w0;
        arb_enable = 1'b1;
        for (int i = 0; i < N; i++) seq[i] = 0;
        do_reset();

        // Single requester 1, three beats
        push_burst(1, 3, 1'b1);
        g0 = glog_idx.size(); w0 = wr_total;
        run(8);
        chk("t1_writes", 64'(wr_total - w0), 64'd3);
        chk("t1_grant_idx", 64'(gidx_at(g0)), 64'd1);
        chk("t1_beats", 64'(gbeats_at(g0)), 64'd3);
        // Pointer now at 2: requester 2 beats requester 0
        push_burst(0, 1, 1'b1);
        push_burst(2, 1, 1'b1);
        g0 = glog_idx.size();
        run(6);
        chk("t1_ptr_first", 64'(gidx_at(g0)), 64'd2);
        chk("t1_ptr_second", 64'(gidx_at(g0 + 1)), 64'd0);

        // All three requesters, two-beat bursts, round-robin order
        do_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) push_burst(i, 2, 1'b1);
        g0 = glog_idx.size();
        run(24);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_order_%0d", k), 64'(gidx_at(g0 + k)), 64'(k % N));
            chk($sformatf("t2_beats_%0d", k), 64'(gbeats_at(g0 + k)), 64'd2);
        end

        // Burst cut at BURST_MAX beats
        do_reset();
        push_burst(0, BM, 1'b0);
        push_burst(1, 2, 1'b1);
        g0 = glog_idx.size();
        run(26);
        chk("t3_first_idx", 64'(gidx_at(g0)), 64'd0);
        chk("t3_first_beats", 64'(gbeats_at(g0)), 64'(BM));
        chk("t3_second_idx", 64'(gidx_at(g0 + 1)), 64'd1);

        // data_full stall inside a 5-beat burst
        do_reset();
        push_burst(2, 5, 1'b1);
        g0 = glog_idx.size(); w0 = wr_total;
        run(2);
        force_df = 1'b1;
        run(3);
        force_df = 1'b0;
        run(8);
        chk("t4_writes", 64'(wr_total - w0), 64'd5);
        chk("t4_beats", 64'(gbeats_at(g0)), 64'd5);
        chk("t4_drained", 64'(pq[2].size()), 64'd0);
`ifdef GIN_ARB_STATS_EN
        chk("t4_beat_count", 64'(beat_count), 64'd5);
        chk("t4_stall_count", 64'(stall_count), 64'd3);
`endif

        // Reset mid-burst after two beats
        do_reset();
        push_burst(1, 5, 1'b1);
        w0 = wr_total;
        run(3);
        chk("t5_pre_writes", 64'(wr_total - w0), 64'd2);
        do_reset();
        push_burst(1, 2, 1'b1);
        push_burst(0, 2, 1'b1);
        g0 = glog_idx.size();
        run(10);
        chk("t5_restart_first", 64'(gidx_at(g0)), 64'd0);
        chk("t5_restart_second", 64'(gidx_at(g0 + 1)), 64'd1);

        // arb_enable gating
        do_reset();
        arb_enable = 1'b0;
        push_burst(0, 3, 1'b1);
        g0 = glog_idx.size();
        run(6);
        chk("t6_no_grant", 64'(glog_idx.size() - g0), 64'd0);
        arb_enable = 1'b1;
        push_burst(1, 2, 1'b1);
        run(2);
        arb_enable = 1'b0;
        run(8);
        chk("t6_one_grant", 64'(glog_idx.size() - g0), 64'd1);
        chk("t6_burst_done", 64'(gbeats_at(g0)), 64'd3);
        chk("t6_req1_waiting", 64'(pq[1].size()), 64'd2);
        arb_enable = 1'b1;
        run(6);
        chk("t6_resume_idx", 64'(gidx_at(g0 + 1)), 64'd1);

        // Randomized traffic with gaps, random fulls and random arb_enable
        do_reset();
        gaps = 1'b1;
        rnd_full = 1'b1;
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 8 && $urandom_range(0, 3) == 0)
                    push_burst(i, int'($urandom_range(1, 20)), 1'b1);
            end
            arb_enable = ($urandom_range(0, 9) != 0);
            drive();
            tick();
        end
        gaps = 1'b0;
        rnd_full = 1'b0;
        arb_enable = 1'b1;
        run(300);
        for (int i = 0; i < N; i++)
            chk($sformatf("t7_drained_%0d", i), 64'(pq[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
